// File: rtl/videofifo_pkg.sv
// Shared types and constants for the video framebuffer fetch path:
// fetch-state encoding, byte-lane geometry and a constant log2 helper.
package videofifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/videofifo_ram.sv
// Generic synchronous word FIFO with combinational head read and a
// synchronous flush that empties it without touching the storage.
module videofifo_ram #(
    parameter int WIDTH = 32,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    fill,
    output logic [WIDTH-1:0] head
);

    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2:0]   DEPTH_C   = {1'b1, {LOG2{1'b0}}};
    localparam logic [LOG2:0]   FILL_ONE  = {{LOG2{1'b0}}, 1'b1};
    localparam logic [LOG2-1:0] PTR_ONE   = {{(LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [LOG2-1:0]  wr_ptr_r;
    logic [LOG2-1:0]  rd_ptr_r;
    logic [LOG2:0]    fill_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push at full is accepted only when a pop frees a slot in the same cycle
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (flush) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (fill_r != {(LOG2+1){1'b0}});
            do_push_s = push && ((fill_r != DEPTH_C) || do_pop_s);
        end
    end

    // Word storage; not reset, validity is tracked by the fill count
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and fill count
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {LOG2{1'b0}};
            rd_ptr_r <= {LOG2{1'b0}};
            fill_r   <= {(LOG2+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   fill_r <= fill_r + FILL_ONE;
                2'b01:   fill_r <= fill_r - FILL_ONE;
                default: fill_r <= fill_r;
            endcase
        end
    end

    assign full  = (fill_r == DEPTH_C);
    assign empty = (fill_r == {(LOG2+1){1'b0}});
    assign fill  = fill_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/videofifo_fetch.sv
// Framebuffer prefetcher: reads words over a req/ack port into a word FIFO
// and serves bytes to the display; VIDEOFIFO_UNDERFLOW_CNT_EN adds underflow_cnt.
module videofifo_fetch
    import videofifo_pkg::*;
#(
    parameter int C_addr_bits   = 30,
    parameter int C_fifo_log2   = 4,
    parameter int C_frame_words = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C_addr_bits-1:0] base_addr,
    input  logic                   vga_vsync_n,
    input  logic                   rd,
    output logic [BYTE_W-1:0]      data_out,
    output logic                   mem_req,
    output logic [C_addr_bits-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_data,
    output logic                   underflow
`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]            underflow_cnt
`endif
);

    localparam int FETCH_W = clog2(C_frame_words + 1);
    localparam int LANE_W  = clog2(LANES);
    localparam logic [FETCH_W-1:0]     FRAME_C   = FETCH_W'(C_frame_words);
    localparam logic [FETCH_W-1:0]     FETCH_ONE = {{(FETCH_W-1){1'b0}}, 1'b1};
    localparam logic [C_addr_bits-1:0] ADDR_ONE  = {{(C_addr_bits-1){1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0]      LANE_ONE  = {{(LANE_W-1){1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0]      LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [C_fifo_log2:0]   DEPTH_C   = {1'b1, {C_fifo_log2{1'b0}}};

    logic                   vs_meta_r;
    logic                   vs_sync_r;
    logic                   vs_prev_r;
    logic                   frame_start_s;
    fetch_state_t           state_r;
    logic                   mem_req_r;
    logic [C_addr_bits-1:0] mem_addr_r;
    logic [FETCH_W-1:0]     fetched_r;
    logic [LANE_W-1:0]      lane_r;
    logic                   underflow_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   rd_ok_s;
    logic                   rd_empty_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [C_fifo_log2:0]   fifo_fill_s;
    logic [31:0]            head_s;

    videofifo_ram #(
        .WIDTH (32),
        .LOG2  (C_fifo_log2)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .flush     (frame_start_s),
        .push      (push_s),
        .push_data (mem_data),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .fill      (fifo_fill_s),
        .head      (head_s)
    );

    // vsync_n synchronizer plus edge-detect flop; idles high so reset is no edge
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_meta_r <= 1'b1;
            vs_sync_r <= 1'b1;
            vs_prev_r <= 1'b1;
        end else begin
            vs_meta_r <= vga_vsync_n;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
        end
    end

    assign frame_start_s = vs_prev_r && !vs_sync_r;

    // frame_start outranks both the display read and the memory ack
    always_comb begin
        rd_ok_s    = 1'b0;
        rd_empty_s = 1'b0;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        if (frame_start_s) begin
            rd_ok_s    = 1'b0;
            rd_empty_s = 1'b0;
            pop_s      = 1'b0;
            push_s     = 1'b0;
        end else begin
            rd_ok_s    = rd && !fifo_empty_s;
            rd_empty_s = rd && fifo_empty_s;
            pop_s      = rd_ok_s && (lane_r == LANE_LAST);
            push_s     = (state_r == REQ) && mem_ack && (!fifo_full_s || pop_s);
        end
    end

    // Fetch FSM: at most one request in flight; DISCARD drains a request
    // that was outstanding when the frame restarted
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= base_addr;
            fetched_r  <= {FETCH_W{1'b0}};
        end else if (frame_start_s) begin
            fetched_r  <= {FETCH_W{1'b0}};
            mem_addr_r <= base_addr;
            if ((state_r != IDLE) && !mem_ack) begin
                state_r   <= DISCARD;
                mem_req_r <= 1'b1;
            end else begin
                state_r   <= IDLE;
                mem_req_r <= 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if ((fifo_fill_s < DEPTH_C) && (fetched_r < FRAME_C)) begin
                        state_r   <= REQ;
                        mem_req_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_r    <= IDLE;
                        mem_req_r  <= 1'b0;
                        mem_addr_r <= mem_addr_r + ADDR_ONE;
                        fetched_r  <= fetched_r + FETCH_ONE;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Byte lane within the head word and the sticky underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_r      <= {LANE_W{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            if (frame_start_s) begin
                lane_r <= {LANE_W{1'b0}};
            end else if (rd_ok_s) begin
                lane_r <= lane_r + LANE_ONE;
            end
            if (rd_empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_r;

    // Saturating count of reads against an empty FIFO; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_cnt_r <= 16'h0000;
        end else if (rd_empty_s && (underflow_cnt_r != 16'hFFFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 16'h0001;
        end
    end

    assign underflow_cnt = underflow_cnt_r;
`endif

    // Little-endian byte select from the head word; zero while empty
    always_comb begin
        data_out = 8'h00;
        if (fifo_empty_s) begin
            data_out = 8'h00;
        end else begin
            data_out = head_s[{lane_r, 3'b000} +: BYTE_W];
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_videofifo_fetch.sv
// Scoreboard bench for videofifo_fetch: expected request addresses and bytes
// are queued by the stimulus and checked by a monitor on req rise and rd.
module tb_videofifo_fetch;

    localparam int AW    = 30;
    localparam int FL    = 4;
    localparam int FRAME = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] base_addr;
    logic          vga_vsync_n;
    logic          rd;
    logic [7:0]    data_out;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;
    logic          underflow;
`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];

    always #5 clk = ~clk;

    videofifo_fetch #(
        .C_addr_bits   (AW),
        .C_fifo_log2   (FL),
        .C_frame_words (FRAME)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .base_addr     (base_addr),
        .vga_vsync_n   (vga_vsync_n),
        .rd            (rd),
        .data_out      (data_out),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .underflow     (underflow)
`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rd(input logic [7:0] exp);
        exp_byte_q.push_back(exp);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(1);
    endtask

    task automatic rd_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            do_rd(w[8*k +: 8]);
        end
    endtask

    task automatic expect_reqs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(first + 32'(i));
        end
    endtask

    // Memory: acks mem_lat cycles after first seeing a request, data = address
    initial begin : mem_model
        logic [AW-1:0] cap;
        int cnt;
        cnt      = 0;
        cap      = '0;
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req === 1'b1) begin
                if (cnt == 0) cap = mem_addr;
                if (cnt >= mem_lat) begin
                    mem_ack  = 1'b1;
                    mem_data = {2'b00, cap};
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: request address on each mem_req rise, byte on each rd
    initial begin : monitor
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((mem_req === 1'b1) && !req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_addr: unexpected request to 0x%0h, none expected", mem_addr);
                end else begin
                    check("req_addr", {2'b00, mem_addr}, exp_addr_q.pop_front());
                end
            end
            req_prev = (mem_req === 1'b1);
            if (rd === 1'b1) begin
                if (exp_byte_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_byte: unexpected rd with data_out 0x%0h", data_out);
                end else begin
                    check("rd_byte", {24'h0, data_out}, {24'h0, exp_byte_q.pop_front()});
                end
            end
        end
    end

    initial begin : stimulus
        int w;
        reset       = 1'b1;
        base_addr   = 30'h100;
        vga_vsync_n = 1'b1;
        rd          = 1'b0;
        tick(3);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_underflow", {31'h0, underflow}, 32'h0);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_mem_addr", {2'b00, mem_addr}, 32'h100);
`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
        check("rst_uf_cnt", {16'h0, underflow_cnt}, 32'h0);
`endif

        // Initial fill stops at 16 words
        expect_reqs(32'h100, 16);
        reset = 1'b0;
        tick(80);
        check("fill_reqs_done", 32'(exp_addr_q.size()), 32'h0);
        check("fill_idle", {31'h0, mem_req}, 32'h0);
        check("fill_data_out", {24'h0, data_out}, 32'h00);

        // Eight reads pop two words and trigger two refills
        expect_reqs(32'h110, 2);
        rd_word(32'h100);
        rd_word(32'h101);
        tick(20);
        check("refill_reqs_done", 32'(exp_addr_q.size()), 32'h0);
        check("refill_bytes_done", 32'(exp_byte_q.size()), 32'h0);
        check("refill_idle", {31'h0, mem_req}, 32'h0);

        // Frame restart with lane mid-word: 3 clk latency, flush, new base
        base_addr = 30'h2A5;
        do_rd(8'h02);
        do_rd(8'h01);
        vga_vsync_n = 1'b0;
        tick(2);
        check("vs_not_yet_addr", {2'b00, mem_addr}, 32'h112);
        tick(1);
        check("vs_addr_base", {2'b00, mem_addr}, 32'h2A5);
        check("vs_req_low", {31'h0, mem_req}, 32'h0);
        check("vs_flushed", {24'h0, data_out}, 32'h0);
        expect_reqs(32'h2A5, 16);
        tick(1);
        check("vs_first_req", {31'h0, mem_req}, 32'h1);
        tick(70);
        check("vs_refill_done", 32'(exp_addr_q.size()), 32'h0);
        expect_reqs(32'h2B5, 1);
        rd_word(32'h2A5);
        tick(10);
        check("vs_reqs_done", 32'(exp_addr_q.size()), 32'h0);

        // Frame restart with a slow request in flight: held, then discarded
        vga_vsync_n = 1'b1;
        mem_lat     = 5;
        base_addr   = 30'h300;
        tick(5);
        expect_reqs(32'h2B6, 1);
        rd_word(32'h2A6);
        w = 0;
        while ((mem_req !== 1'b1) && (w < 10)) begin
            tick(1);
            w++;
        end
        check("disc_req_up", {31'h0, mem_req}, 32'h1);
        vga_vsync_n = 1'b0;
        expect_reqs(32'h300, 1);
        tick(4);
        check("disc_req_held", {31'h0, mem_req}, 32'h1);
        check("disc_addr_base", {2'b00, mem_addr}, 32'h300);
        w = 0;
        while ((mem_req === 1'b1) && (w < 20)) begin
            tick(1);
            w++;
        end
        check("disc_req_dropped", {31'h0, mem_req}, 32'h0);
        mem_lat = 1;
        expect_reqs(32'h301, 15);
        tick(80);
        check("disc_refill_done", 32'(exp_addr_q.size()), 32'h0);

        // Drain the whole frame: fetching stops at FRAME words
        check("pre_underflow", {31'h0, underflow}, 32'h0);
        expect_reqs(32'h310, FRAME - 16);
        for (int i = 0; i < FRAME; i++) begin
            rd_word(32'h300 + 32'(i));
        end
        tick(20);
        check("frame_reqs_done", 32'(exp_addr_q.size()), 32'h0);
        check("frame_bytes_done", 32'(exp_byte_q.size()), 32'h0);
        check("frame_idle", {31'h0, mem_req}, 32'h0);

        // Reads against an empty FIFO
        do_rd(8'h00);
        do_rd(8'h00);
        do_rd(8'h00);
        check("underflow_set", {31'h0, underflow}, 32'h1);
        check("empty_data_out", {24'h0, data_out}, 32'h0);
`ifdef VIDEOFIFO_UNDERFLOW_CNT_EN
        check("underflow_cnt", {16'h0, underflow_cnt}, 32'h3);
`endif
        tick(10);
        check("underflow_sticky", {31'h0, underflow}, 32'h1);
        check("end_idle", {31'h0, mem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
